// File: rtl/sat_ctr_pkg.sv
// -----------------------------------------------------------------------------
// sat_ctr_pkg
// Shared definitions for the saturating-counter predictor table.
//   ctr_word_t : widest supported counter word (CTR_W is 2..8); narrower
//                counters are zero-extended into it for the helpers below.
//   dir_e      : update direction (increment = taken, decrement = not taken).
//   ctr_max    : all-ones saturation limit for a given counter width.
//   is_strong  : 1 when a counter sits at either saturation end.
//   sat_next   : saturating increment/decrement of a counter value.
// -----------------------------------------------------------------------------
package sat_ctr_pkg;

    localparam int CTR_W_MAX = 8;

    typedef logic [CTR_W_MAX-1:0] ctr_word_t;

    typedef enum logic {
        DIR_DEC = 1'b0,
        DIR_INC = 1'b1
    } dir_e;

    // Saturation limit 2^w-1, built bit by bit so no shift overflows at w=8.
    function automatic ctr_word_t ctr_max(input int w);
        ctr_word_t m;
        m = '0;
        for (int i = 0; i < CTR_W_MAX; i++) begin
            m[i] = (i < w);
        end
        return m;
    endfunction

    // A counter is "strong" when pinned at 0 or at its maximum.
    function automatic logic is_strong(input ctr_word_t v, input int w);
        return (v == '0) || (v == ctr_max(w));
    endfunction

    // Saturating step: never wraps past 0 or past the width's maximum.
    function automatic ctr_word_t sat_next(input ctr_word_t v, input dir_e dir, input int w);
        ctr_word_t r;
        r = v;
        case (dir)
            DIR_INC: begin
                if (v == ctr_max(w)) begin
                    r = v;
                end else begin
                    r = v + 8'd1;
                end
            end
            DIR_DEC: begin
                if (v == 8'd0) begin
                    r = v;
                end else begin
                    r = v - 8'd1;
                end
            end
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sat_ctr_next.sv
// -----------------------------------------------------------------------------
// sat_ctr_next
// Combinational next-value logic for one CTR_W-bit saturating counter.
// Ports:
//   v      in  CTR_W : current counter value
//   UpDown in  1     : 1 = increment (taken), 0 = decrement (not taken)
//   next   out CTR_W : saturated next value
// -----------------------------------------------------------------------------
module sat_ctr_next
    import sat_ctr_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] v,
    input  logic             UpDown,
    output logic [CTR_W-1:0] next
);

    // Widen into the package word, step, and narrow back; the saturation
    // limit passed in keeps the upper bits of the result at zero.
    assign next = CTR_W'(sat_next(ctr_word_t'(v), dir_e'(UpDown), CTR_W));

endmodule

// File: rtl/sat_counter_table.sv
// -----------------------------------------------------------------------------
// sat_counter_table
// DEPTH-entry table of CTR_W-bit saturating up/down counters used for
// branch-direction prediction. One registered read port (with same-cycle
// forwarding from the update port) and one update port; Flush reloads
// every entry with INIT in a single cycle, so storage is a flop array.
// Ports:
//   Clk    in  1     : clock, rising edge
//   reset  in  1     : asynchronous active-high reset (table and Count <- INIT)
//   Flush  in  1     : synchronous reload of all entries with INIT
//   Enable in  1     : update valid
//   UpdIdx in  IDX_W : entry to update
//   UpDown in  1     : 1 increments, 0 decrements
//   RdIdx  in  IDX_W : lookup index, sampled every cycle
//   Count  out CTR_W : registered value of the looked-up entry
//   Taken  out 1     : MSB of Count
//   Strong out 1     : Count saturated at 0 or at the maximum
// -----------------------------------------------------------------------------
module sat_counter_table
    import sat_ctr_pkg::*;
#(
    parameter int CTR_W = 2,
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int INIT  = 0
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             Flush,
    input  logic             Enable,
    input  logic [IDX_W-1:0] UpdIdx,
    input  logic             UpDown,
    input  logic [IDX_W-1:0] RdIdx,
    output logic [CTR_W-1:0] Count,
    output logic             Taken,
    output logic             Strong
);

    localparam logic [CTR_W-1:0] INIT_VAL = CTR_W'(INIT);

    logic [CTR_W-1:0] table_r [DEPTH];
    logic [CTR_W-1:0] count_r;
    logic [CTR_W-1:0] upd_cur_s;
    logic [CTR_W-1:0] upd_next_s;
    logic [CTR_W-1:0] rd_next_s;

    assign upd_cur_s = table_r[UpdIdx];

    sat_ctr_next #(
        .CTR_W(CTR_W)
    ) u_next (
        .v      (upd_cur_s),
        .UpDown (UpDown),
        .next   (upd_next_s)
    );

    // Read mux: the value the addressed entry will hold after this edge.
    // Flush wins over everything; a same-index update is forwarded.
    always_comb begin
        rd_next_s = table_r[RdIdx];
        if (Flush) begin
            rd_next_s = INIT_VAL;
        end else if (Enable && (UpdIdx == RdIdx)) begin
            rd_next_s = upd_next_s;
        end else begin
            rd_next_s = table_r[RdIdx];
        end
    end

    // Counter storage: reset/flush reload all entries, otherwise one update.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_r[i] <= INIT_VAL;
            end
        end else if (Flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_r[i] <= INIT_VAL;
            end
        end else if (Enable) begin
            table_r[UpdIdx] <= upd_next_s;
        end
    end

    // Registered read port.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            count_r <= INIT_VAL;
        end else begin
            count_r <= rd_next_s;
        end
    end

    assign Count  = count_r;
    assign Taken  = count_r[CTR_W-1];
    assign Strong = is_strong(ctr_word_t'(count_r), CTR_W);

endmodule

// File: tb/tb_sat_counter_table.sv
module tb_sat_counter_table;

    logic       Clk = 1'b0;
    logic       reset;
    // default instance: CTR_W=2, DEPTH=16, INIT=0
    logic       Flush, Enable, UpDown;
    logic [3:0] UpdIdx, RdIdx;
    logic [1:0] Count;
    logic       Taken, Strong;
    // sweep instance: CTR_W=3, DEPTH=64, INIT=3
    logic       Flush2, Enable2, UpDown2;
    logic [5:0] UpdIdx2, RdIdx2;
    logic [2:0] Count2;
    logic       Taken2, Strong2;

    int tests  = 0;
    int failed = 0;
    int model [16];

    always #5 Clk = ~Clk;

    sat_counter_table dut (
        .Clk(Clk), .reset(reset), .Flush(Flush), .Enable(Enable),
        .UpdIdx(UpdIdx), .UpDown(UpDown), .RdIdx(RdIdx),
        .Count(Count), .Taken(Taken), .Strong(Strong)
    );

    sat_counter_table #(.CTR_W(3), .DEPTH(64), .INIT(3)) dut2 (
        .Clk(Clk), .reset(reset), .Flush(Flush2), .Enable(Enable2),
        .UpdIdx(UpdIdx2), .UpDown(UpDown2), .RdIdx(RdIdx2),
        .Count(Count2), .Taken(Taken2), .Strong(Strong2)
    );

    typedef struct {
        logic       fl;
        logic       en;
        logic [3:0] ui;
        logic       ud;
        logic [3:0] ri;
        logic [1:0] ec;
        logic       et;
        logic       es;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic en, input logic [3:0] ui,
                         input logic ud, input logic [3:0] ri);
        Flush = fl; Enable = en; UpdIdx = ui; UpDown = ud; RdIdx = ri;
    endtask

    // advance one active edge and settle away from it
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // check all three outputs of the default instance against an expected count
    task automatic check_out(input string name, input int exp);
        check({name, ".count"},  32'(Count),  32'(exp));
        check({name, ".taken"},  32'(Taken),  32'(exp >= 2));
        check({name, ".strong"}, 32'(Strong), 32'((exp == 0) || (exp == 3)));
    endtask

    // reference model: saturating counter in plain integer arithmetic
    function automatic int sat_step(input int v, input logic up, input int maxv);
        int r;
        r = up ? v + 1 : v - 1;
        if (r > maxv) r = maxv;
        if (r < 0) r = 0;
        return r;
    endfunction

    initial begin
        int exp;
        reset = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        Flush2 = 1'b0; Enable2 = 1'b0; UpdIdx2 = 6'd0; UpDown2 = 1'b0; RdIdx2 = 6'd0;
        repeat (2) @(posedge Clk);
        #1;
        check_out("reset", 0);
        check("reset2.count",  32'(Count2),  32'd3);
        check("reset2.taken",  32'(Taken2),  32'd0);
        check("reset2.strong", 32'(Strong2), 32'd0);
        reset = 1'b0;

        // ---- table-driven: saturation, forwarding, isolation ----
        //                fl    en    ui     ud    ri     ec    et    es
        vecs.push_back('{1'b0, 1'b1, 4'd5, 1'b1, 4'd5, 2'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'd5, 1'b1, 4'd5, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'd5, 1'b1, 4'd5, 2'd3, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 4'd5, 1'b1, 4'd5, 2'd3, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 4'd5, 1'b0, 4'd5, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'd5, 1'b0, 4'd5, 2'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'd5, 1'b0, 4'd5, 2'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 4'd5, 1'b0, 4'd5, 2'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 4'd5, 1'b0, 4'd5, 2'd0, 1'b0, 1'b1});
        // idx3 -> 1 while reading 0, then forwarded increment to 2
        vecs.push_back('{1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 2'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 4'd3, 1'b1, 4'd3, 2'd2, 1'b1, 1'b0});
        // update idx3 while reading idx4: entry 4 unchanged
        vecs.push_back('{1'b0, 1'b1, 4'd3, 1'b0, 4'd4, 2'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 4'd3, 1'b1, 4'd3, 2'd1, 1'b0, 1'b0});
        // isolation: idx0 up three times, neighbours stay at INIT
        vecs.push_back('{1'b0, 1'b1, 4'd0, 1'b1, 4'd1, 2'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 4'd0, 1'b1, 4'd15, 2'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 4'd0, 1'b1, 4'd1, 2'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 4'd15, 2'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 2'd3, 1'b1, 1'b1});
        // flush alone
        vecs.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].fl, vecs[i].en, vecs[i].ui, vecs[i].ud, vecs[i].ri);
            tick();
            check($sformatf("vec%0d.count", i),  32'(Count),  32'(vecs[i].ec));
            check($sformatf("vec%0d.taken", i),  32'(Taken),  32'(vecs[i].et));
            check($sformatf("vec%0d.strong", i), 32'(Strong), 32'(vecs[i].es));
        end

        // ---- flush priority: all entries at 3, flush with update to idx7 ----
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 3; k++) begin
                drive(1'b0, 1'b1, 4'(i), 1'b1, 4'd0);
                tick();
            end
        end
        drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd9);
        tick();
        check_out("preflush", 3);
        drive(1'b1, 1'b1, 4'd7, 1'b1, 4'd7);
        tick();
        check_out("flush_upd", 0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 4'd0, 1'b0, 4'(i));
            tick();
            check($sformatf("postflush[%0d]", i), 32'(Count), 32'd0);
        end
        for (int i = 0; i < 16; i++) model[i] = 0;

        // ---- randomized against the reference model ----
        for (int n = 0; n < 400; n++) begin
            logic fl, en, ud;
            logic [3:0] ui, ri;
            fl = ($urandom_range(0, 24) == 0);
            en = 1'($urandom_range(0, 1));
            ud = 1'($urandom_range(0, 1));
            ui = 4'($urandom_range(0, 15));
            ri = ($urandom_range(0, 1) == 1) ? ui : 4'($urandom_range(0, 15));
            drive(fl, en, ui, ud, ri);
            tick();
            if (fl) begin
                for (int i = 0; i < 16; i++) model[i] = 0;
            end else if (en) begin
                model[ui] = sat_step(model[ui], ud, 3);
            end
            check_out($sformatf("rand%0d", n), model[ri]);
        end

        // ---- asynchronous reset mid-cycle while an update is pending ----
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 4'd6, 1'b1, 4'd6);
            tick();
        end
        check_out("dirty", 3);
        drive(1'b0, 1'b1, 4'd6, 1'b1, 4'd6);
        #2;
        reset = 1'b1;
        #1;
        check_out("async_reset", 0);
        @(posedge Clk);          // update presented under reset is discarded
        #1;
        check_out("reset_hold", 0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 4'd0, 1'b0, 4'(i));
            tick();
            check($sformatf("postreset[%0d]", i), 32'(Count), 32'd0);
        end

        // ---- parameter sweep instance: ten increments from INIT=3 ----
        check("sweep_init.count", 32'(Count2), 32'd3);
        Enable2 = 1'b1; UpdIdx2 = 6'd42; UpDown2 = 1'b1; RdIdx2 = 6'd42;
        exp = 3;
        for (int k = 0; k < 10; k++) begin
            tick();
            exp = sat_step(exp, 1'b1, 7);
            check($sformatf("sweep%0d.count", k),  32'(Count2),  32'(exp));
            check($sformatf("sweep%0d.taken", k),  32'(Taken2),  32'(exp >= 4));
            check($sformatf("sweep%0d.strong", k), 32'(Strong2), 32'((exp == 0) || (exp == 7)));
        end
        Enable2 = 1'b0; RdIdx2 = 6'd43;
        tick();
        check("sweep_neigh.count", 32'(Count2), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sat_counter_table.md
# sat_counter_table

Parametrised table of saturating up/down counters for branch-direction prediction. It generalises the single 2-bit predictor to `DEPTH` independently indexed entries of `CTR_W` bits. It has one registered read port and one update port, with same-cycle update-to-read forwarding and a synchronous table flush. It sits between the fetch-side lookup logic (read port) and the resolve-side training logic (update port).

## Interface
Parameters:
- `CTR_W`, default 2: counter width in bits, legal range 2..8.
- `DEPTH`, default 16: number of entries, power of two, legal range 2..1024.
- `IDX_W`, default $clog2(DEPTH): index width. Derived; never overridden.
- `INIT`, default 0: value loaded on reset and flush. Must be less than 2^CTR_W.

Ports:
- `Clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `Flush` in 1: synchronous; loads `INIT` into every entry.
- `Enable` in 1: update valid.
- `UpdIdx` in IDX_W: entry to update.
- `UpDown` in 1: update direction. 1 increments (taken), 0 decrements (not taken).
- `RdIdx` in IDX_W: lookup index, sampled every cycle.
- `Count` out CTR_W: registered value of the looked-up entry.
- `Taken` out 1: MSB of `Count`.
- `Strong` out 1: 1 when `Count` is 0 or 2^CTR_W−1 (saturated at either end).

## Operation
- Each entry is a `CTR_W`-bit unsigned counter.
- Update when `Enable`=1 and `Flush`=0:
  - entry[UpdIdx] ← min(v+1, MAX) if `UpDown`=1.
  - entry[UpdIdx] ← max(v−1, 0) if `UpDown`=0.
  - MAX = 2^CTR_W−1. Counters saturate; they never wrap.
- `Enable`=0: no entry changes.
- `Flush`=1: every entry ← `INIT` at that edge. `Flush` overrides a same-cycle update.
- Read, every cycle:
  - `Count` ← the value entry[RdIdx] holds after the current edge's update or flush.
  - Forwarding case: `Enable`=1 and `UpdIdx`==`RdIdx`. `Count` gets the post-update value, not the stale one.
  - Flush case: `Flush`=1 makes `Count` ← `INIT` regardless of `RdIdx`.
- `Taken` and `Strong` are combinational decodes of the registered `Count`. They never come from a separate path.
- `CTR_W`=2 decodes: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- No state machine beyond the per-entry counters. Each entry is its own saturating up/down FSM with 2^CTR_W states.

## Timing
- Asserting `reset` asynchronously clears outputs and table:
  - all entries = `INIT`.
  - `Count` = `INIT`.
  - `Taken` = INIT[CTR_W−1].
  - `Strong` = (INIT==0 or INIT==MAX).
  - Defaults (INIT=0): `Count`=0, `Taken`=0, `Strong`=1.
- Deassertion is taken at the next rising edge; the first update is accepted at that edge.
- Read latency: 1 cycle. `RdIdx` presented before edge N gives `Count` valid after edge N.
- Update latency: 1 cycle. A read of the same index issued at the next edge sees the new value.
- Same-edge read of the same index sees the new value through forwarding.
- Boundary cases:
  - Increment at MAX holds MAX.
  - Decrement at 0 holds 0.
  - Reset mid-update discards the update.
  - Flush and update to the same index in one cycle: entry = `INIT`, and `Count` = `INIT` if read.
- No back-pressure: every cycle accepts one read and one update.

## Structure
- Package `sat_ctr_pkg` holds:
  - the `CTR_W`-dependent constants (MAX),
  - the strong-state decode function,
  - the saturating next-value function.
- Sub-module `sat_ctr_next` (combinational): inputs `v`, `UpDown`; output saturated next value. It is instantiated once on the update path.
- Table storage is a flop array; it is not inferred RAM, because flush touches every entry in one cycle.
- Read mux and forwarding compare live in the top.

## Test plan
- Reset: assert `reset` mid-cycle with entries dirty → `Count`=0, `Taken`=0, `Strong`=1 immediately. Read every index → 0.
- Saturation: CTR_W=2, idx 5, four updates with `UpDown`=1 → reads 1, 2, 3, 3 (`Strong`=1 at 3). Five with `UpDown`=0 → 2, 1, 0, 0, 0.
- Forwarding: idx 3 holds 1. Same cycle: `Enable`=1, `UpdIdx`=3, `UpDown`=1, `RdIdx`=3 → `Count`=2, `Taken`=1, `Strong`=0. `RdIdx`=4 in the same scenario → entry 4 unchanged.
- Isolation: update idx 0 up three times → idx 1 and idx 15 still read `INIT`.
- Flush priority: entries at 3. `Flush`=1 with `Enable`=1, `UpdIdx`=7 → all entries `INIT`, `Count`=`INIT` next cycle.
- Parameter sweep: CTR_W=3, DEPTH=64, INIT=3 → reset `Count`=3, `Taken`=0, `Strong`=0. Ten increments → saturate at 7, `Strong`=1.
